// File: rtl/rs_ctrl_pkg.sv
// Shared constants for the RS frame controller: state encoding, default geometry
// and the counter width helper.
package rs_ctrl_pkg;

    localparam int K_DEF           = 8;
    localparam int NPAR_DEF        = 4;
    localparam int TIMEOUT_CYC_DEF = 100000;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_FLUSH     = 3'd2;
    localparam logic [2:0] ST_SEND      = 3'd3;
    localparam logic [2:0] ST_SEND_WAIT = 3'd4;

    // Width that can hold every value 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rs_frame_buf.sv
// Frame storage for message and parity bytes: one write port and one
// registered read port.
module rs_frame_buf #(
    parameter int DEPTH = 12,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/rs_frame_ctrl.sv
// Frames UART bytes through an external RS encoder and retransmits message plus
// parity. Optional inter-byte timeout in LOAD is compiled in with RS_FRAME_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | waiting for the first byte of a frame
// LOAD       | feeding message bytes to the encoder
// FLUSH      | collecting parity bytes from the encoder
// SEND       | waiting for the transmitter, then launching slot[idx]
// SEND_WAIT  | transmitter working on the launched byte
module rs_frame_ctrl
    import rs_ctrl_pkg::*;
#(
    parameter int K           = K_DEF,
    parameter int NPAR        = NPAR_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       enc_clr,
    output logic       enc_ce,
    output logic [7:0] enc_din,
    input  logic [7:0] enc_dout,
    input  logic       enc_dout_valid,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       busy,
    output logic       frame_done,
    output logic       rx_drop,
    output logic       frame_abort
);

    localparam int N  = K + NPAR;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] MSG_LAST = CW'(K - 1);
    localparam logic [CW-1:0] FRM_LAST = CW'(N - 1);
    localparam logic [CW-1:0] FRM_LEN  = CW'(N);

    // Elaborates only for out-of-range geometry so it shows up in the hierarchy.
    if (K < 2 || K > 64 || NPAR < 1 || NPAR > 16 || TIMEOUT_CYC < 1) begin : g_param_out_of_range
    end

    logic [2:0]    state;
    logic          rx_valid_q;
    logic          rx_arm;
    logic          rx_rise;
    logic [7:0]    cap_q;
    logic          ce_pend;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] idx;
    logic          wait_first;
    logic          tmo_hit;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic [7:0]    rd_data;

    // rx_arm keeps a level still held across reset release from looking like a new byte.
    assign rx_rise = rx_valid & ~rx_valid_q & rx_arm;
    assign enc_din = cap_q;
    assign busy    = (state != ST_IDLE);
    assign wr_en   = enc_ce | ((state == ST_FLUSH) & enc_dout_valid);
    assign wr_data = (state == ST_FLUSH) ? enc_dout : cap_q;

    rs_frame_buf #(
        .DEPTH (N),
        .AW    (CW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_cnt),
        .wr_data (wr_data),
        .rd_addr (idx),
        .rd_data (rd_data)
    );

`ifdef RS_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (state == ST_LOAD) && !rx_rise && (tmo_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt     <= '0;
            frame_abort <= 1'b0;
        end else begin
            frame_abort <= tmo_hit;
            if (state != ST_LOAD || rx_rise) tmo_cnt <= TW'(TIMEOUT_CYC - 1);
            else if (tmo_cnt != '0)          tmo_cnt <= tmo_cnt - 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign frame_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            rx_valid_q <= 1'b0;
            rx_arm     <= 1'b0;
            cap_q      <= 8'h00;
            ce_pend    <= 1'b0;
            wr_cnt     <= '0;
            idx        <= '0;
            wait_first <= 1'b0;
            enc_clr    <= 1'b0;
            enc_ce     <= 1'b0;
            tx_data    <= 8'h00;
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            rx_drop    <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            if (!rx_valid) rx_arm <= 1'b1;
            enc_clr    <= 1'b0;
            enc_ce     <= ce_pend;
            ce_pend    <= 1'b0;
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            rx_drop    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (rx_rise) begin
                        cap_q   <= rx_data;
                        enc_clr <= 1'b1;
                        ce_pend <= 1'b1;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (rx_rise) begin
                        cap_q  <= rx_data;
                        enc_ce <= 1'b1;
                    end
                    if (enc_ce) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == MSG_LAST) state <= ST_FLUSH;
                    end else if (tmo_hit) begin
                        wr_cnt <= '0;
                        idx    <= '0;
                        state  <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (rx_rise) rx_drop <= 1'b1;
                    if (enc_dout_valid) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == FRM_LAST) state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (rx_rise) rx_drop <= 1'b1;
                    // idx advances at launch so the read port settles during SEND_WAIT.
                    if (!tx_busy) begin
                        tx_data    <= rd_data;
                        tx_start   <= 1'b1;
                        idx        <= idx + 1'b1;
                        wait_first <= 1'b1;
                        state      <= ST_SEND_WAIT;
                    end
                end
                ST_SEND_WAIT: begin
                    if (rx_rise) rx_drop <= 1'b1;
                    if (wait_first) begin
                        wait_first <= 1'b0;
                    end else if (!tx_busy) begin
                        if (idx == FRM_LEN) begin
                            frame_done <= 1'b1;
                            wr_cnt     <= '0;
                            idx        <= '0;
                            state      <= ST_IDLE;
                        end else begin
                            state <= ST_SEND;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
